// File: rtl/hall_call_register_pkg.sv
// Shared definitions for the hall/car call register: direction codes,
// default sizing and floor matching.
package hall_call_register_pkg;

  localparam int DEF_NUM_FLOORS = 4;
  localparam int DEF_POS_W      = 3;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  function automatic logic floor_match(input int unsigned position, input int unsigned index);
    return position == index;
  endfunction

endpackage

// File: rtl/hall_call_register_if.sv
// Button/position inputs and pending-request outputs of the call register.
interface hall_call_register_if
  import hall_call_register_pkg::*;
#(
  parameter int NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int POS_W      = DEF_POS_W
);

  logic [NUM_FLOORS-2:0] button_up;
  logic [NUM_FLOORS-2:0] button_down;
  logic [NUM_FLOORS-1:0] button_in;
  logic [POS_W-1:0]      position;
  logic                  open;
  logic [1:0]            direction;
  logic [NUM_FLOORS-2:0] pend_up;
  logic [NUM_FLOORS-2:0] pend_down;
  logic [NUM_FLOORS-1:0] pend_in;
  logic                  req_above;
  logic                  req_below;
  logic                  req_here;
  logic                  any_req;

  modport master (
    output button_up, button_down, button_in, position, open, direction,
    input  pend_up, pend_down, pend_in, req_above, req_below, req_here, any_req
  );

  modport slave (
    input  button_up, button_down, button_in, position, open, direction,
    output pend_up, pend_down, pend_in, req_above, req_below, req_here, any_req
  );

endinterface

// File: rtl/hall_call_register_rise_detect.sv
// One-bit button edge detector: history flop plus 0->1 pulse.
module hall_call_register_rise_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic button,
  output logic rise
);

  logic hist_p0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hist_p0 <= 1'b0;
    else          hist_p0 <= button;
  end

  assign rise = button & ~hist_p0;

endmodule

// File: rtl/hall_call_register.sv
// Latches hall and car calls until served by an open door at that floor,
// and registers above/below/here summary flags from the next pending state.
module hall_call_register
  import hall_call_register_pkg::*;
#(
  parameter int NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int POS_W      = DEF_POS_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  hall_call_register_if.slave   bus
);

  localparam int NH = NUM_FLOORS - 1;

  logic [NH-1:0]         rise_up, rise_down, clr_up, clr_down, nxt_up, nxt_down;
  logic [NH-1:0]         pend_up_p0, pend_down_p0;
  logic [NUM_FLOORS-1:0] rise_in, clr_in, nxt_in, pend_in_p0, floor_req;
  logic [POS_W-1:0]      pos;
  int unsigned           pos_i;
  logic                  pos_valid, svc, go_up, go_down;
  logic                  nxt_above, nxt_below, nxt_here, nxt_any;
  logic                  above_p0, below_p0, here_p0, any_p0;

  for (genvar i = 0; i < NH; i++) begin : g_hall
    hall_call_register_rise_detect u_up (
      .clk(clk), .reset_n(reset_n), .button(bus.button_up[i]), .rise(rise_up[i])
    );
    hall_call_register_rise_detect u_down (
      .clk(clk), .reset_n(reset_n), .button(bus.button_down[i]), .rise(rise_down[i])
    );
  end

  for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_car
    hall_call_register_rise_detect u_in (
      .clk(clk), .reset_n(reset_n), .button(bus.button_in[i]), .rise(rise_in[i])
    );
  end

  assign pos   = bus.position;
  assign pos_i = 32'(pos);

  always_comb begin
    pos_valid = pos_i < NUM_FLOORS;
    svc       = bus.open && pos_valid;
    // Direction 2'b11 falls through as idle, clearing both hall calls.
    go_up     = bus.direction != DIR_DOWN;
    go_down   = bus.direction != DIR_UP;
    clr_up    = '0;
    clr_down  = '0;
    clr_in    = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++)
      clr_in[i] = svc && floor_match(pos_i, i);
    for (int unsigned i = 0; i < NH; i++) begin
      clr_up[i]   = svc && floor_match(pos_i, i) && (go_up || i == 0);
      clr_down[i] = svc && floor_match(pos_i, i + 1) && (go_down || i + 1 == NH);
    end

    // Clear beats a same-edge press: the open door absorbs the request.
    nxt_up   = (pend_up_p0 | rise_up) & ~clr_up;
    nxt_down = (pend_down_p0 | rise_down) & ~clr_down;
    nxt_in   = (pend_in_p0 | rise_in) & ~clr_in;

    floor_req = nxt_in;
    for (int unsigned i = 0; i < NH; i++) begin
      floor_req[i]   = floor_req[i] | nxt_up[i];
      floor_req[i+1] = floor_req[i+1] | nxt_down[i];
    end

    nxt_any   = |floor_req;
    nxt_above = 1'b0;
    nxt_below = 1'b0;
    nxt_here  = 1'b0;
    for (int unsigned f = 0; f < NUM_FLOORS; f++) begin
      if (floor_req[f]) begin
        if (!pos_valid || f > pos_i)  nxt_above = 1'b1;
        if (pos_valid && f < pos_i)   nxt_below = 1'b1;
        if (floor_match(pos_i, f))    nxt_here  = 1'b1;
      end
    end
  end

  // Stage p0: pending vectors and summary flags register together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_up_p0   <= '0;
      pend_down_p0 <= '0;
      pend_in_p0   <= '0;
      above_p0     <= 1'b0;
      below_p0     <= 1'b0;
      here_p0      <= 1'b0;
      any_p0       <= 1'b0;
    end else begin
      pend_up_p0   <= nxt_up;
      pend_down_p0 <= nxt_down;
      pend_in_p0   <= nxt_in;
      above_p0     <= nxt_above;
      below_p0     <= nxt_below;
      here_p0      <= nxt_here;
      any_p0       <= nxt_any;
    end
  end

  assign bus.pend_up   = pend_up_p0;
  assign bus.pend_down = pend_down_p0;
  assign bus.pend_in   = pend_in_p0;
  assign bus.req_above = above_p0;
  assign bus.req_below = below_p0;
  assign bus.req_here  = here_p0;
  assign bus.any_req   = any_p0;

endmodule

// File: tb/tb_hall_call_register.sv
// Directed vector bench for hall_call_register (4 floors).
module tb_hall_call_register;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_bad;

  hall_call_register_if #(.NUM_FLOORS(4), .POS_W(3)) bus ();

  hall_call_register #(.NUM_FLOORS(4), .POS_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected = {pend_up[3], pend_down[3], pend_in[4], above, below, here, any}
  typedef struct {
    logic [2:0]  up;
    logic [2:0]  down;
    logic [3:0]  in_b;
    logic [2:0]  pos;
    logic        open;
    logic [1:0]  dir;
    logic [13:0] exp;
  } vec_t;

  vec_t tbl[25];

  function automatic logic [13:0] outs();
    return {bus.pend_up, bus.pend_down, bus.pend_in,
            bus.req_above, bus.req_below, bus.req_here, bus.any_req};
  endfunction

  task automatic check(input string name, input logic [13:0] exp);
    logic [13:0] act;
    act = outs();
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got up=%b dn=%b in=%b abhy=%b, want up=%b dn=%b in=%b abhy=%b",
               name, act[13:11], act[10:8], act[7:4], act[3:0],
               exp[13:11], exp[10:8], exp[7:4], exp[3:0]);
    end
  endtask

  task automatic drive(input logic [2:0] up, input logic [2:0] down, input logic [3:0] in_b,
                       input logic [2:0] pos, input logic open, input logic [1:0] dir);
    bus.button_up   = up;
    bus.button_down = down;
    bus.button_in   = in_b;
    bus.position    = pos;
    bus.open        = open;
    bus.direction   = dir;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;

    tbl[0]  = '{3'b010, 3'b000, 4'b0000, 3'd0, 1'b0, 2'b00, {3'b010, 3'b000, 4'b0000, 4'b1001}};
    tbl[1]  = '{3'b010, 3'b000, 4'b0000, 3'd0, 1'b0, 2'b00, {3'b010, 3'b000, 4'b0000, 4'b1001}};
    tbl[2]  = '{3'b000, 3'b000, 4'b0000, 3'd0, 1'b0, 2'b00, {3'b010, 3'b000, 4'b0000, 4'b1001}};
    tbl[3]  = '{3'b000, 3'b000, 4'b0000, 3'd1, 1'b1, 2'b01, {3'b000, 3'b000, 4'b0000, 4'b0000}};
    tbl[4]  = '{3'b100, 3'b010, 4'b0000, 3'd0, 1'b0, 2'b00, {3'b100, 3'b010, 4'b0000, 4'b1001}};
    tbl[5]  = '{3'b000, 3'b000, 4'b0000, 3'd2, 1'b1, 2'b01, {3'b000, 3'b010, 4'b0000, 4'b0011}};
    tbl[6]  = '{3'b000, 3'b000, 4'b0000, 3'd2, 1'b1, 2'b10, {3'b000, 3'b000, 4'b0000, 4'b0000}};
    tbl[7]  = '{3'b000, 3'b100, 4'b0000, 3'd0, 1'b0, 2'b00, {3'b000, 3'b100, 4'b0000, 4'b1001}};
    tbl[8]  = '{3'b000, 3'b000, 4'b0000, 3'd3, 1'b1, 2'b01, {3'b000, 3'b000, 4'b0000, 4'b0000}};
    tbl[9]  = '{3'b001, 3'b000, 4'b0000, 3'd3, 1'b0, 2'b00, {3'b001, 3'b000, 4'b0000, 4'b0101}};
    tbl[10] = '{3'b000, 3'b000, 4'b0000, 3'd0, 1'b1, 2'b10, {3'b000, 3'b000, 4'b0000, 4'b0000}};
    tbl[11] = '{3'b000, 3'b000, 4'b0100, 3'd2, 1'b1, 2'b00, {3'b000, 3'b000, 4'b0000, 4'b0000}};
    tbl[12] = '{3'b000, 3'b000, 4'b0100, 3'd2, 1'b0, 2'b00, {3'b000, 3'b000, 4'b0000, 4'b0000}};
    tbl[13] = '{3'b000, 3'b000, 4'b0000, 3'd2, 1'b0, 2'b00, {3'b000, 3'b000, 4'b0000, 4'b0000}};
    tbl[14] = '{3'b111, 3'b111, 4'b1111, 3'd5, 1'b0, 2'b00, {3'b111, 3'b111, 4'b1111, 4'b1001}};
    tbl[15] = '{3'b000, 3'b000, 4'b0000, 3'd5, 1'b1, 2'b00, {3'b111, 3'b111, 4'b1111, 4'b1001}};
    tbl[16] = '{3'b000, 3'b000, 4'b0000, 3'd1, 1'b0, 2'b00, {3'b111, 3'b111, 4'b1111, 4'b1111}};
    tbl[17] = '{3'b000, 3'b000, 4'b0000, 3'd1, 1'b1, 2'b01, {3'b101, 3'b111, 4'b1101, 4'b1111}};
    tbl[18] = '{3'b000, 3'b000, 4'b0000, 3'd1, 1'b1, 2'b00, {3'b101, 3'b110, 4'b1101, 4'b1101}};
    tbl[19] = '{3'b000, 3'b000, 4'b0000, 3'd0, 1'b1, 2'b00, {3'b100, 3'b110, 4'b1100, 4'b1001}};
    tbl[20] = '{3'b000, 3'b000, 4'b0000, 3'd2, 1'b1, 2'b00, {3'b000, 3'b100, 4'b1000, 4'b1001}};
    tbl[21] = '{3'b000, 3'b000, 4'b0000, 3'd3, 1'b1, 2'b10, {3'b000, 3'b000, 4'b0000, 4'b0000}};
    tbl[22] = '{3'b010, 3'b001, 4'b0000, 3'd0, 1'b0, 2'b00, {3'b010, 3'b001, 4'b0000, 4'b1001}};
    tbl[23] = '{3'b000, 3'b000, 4'b0000, 3'd1, 1'b1, 2'b11, {3'b000, 3'b000, 4'b0000, 4'b0000}};
    tbl[24] = '{3'b000, 3'b000, 4'b1010, 3'd0, 1'b0, 2'b00, {3'b000, 3'b000, 4'b1010, 4'b1001}};

    // Reset with a car button held: nothing visible until release.
    reset_n = 1'b0;
    drive(3'b000, 3'b000, 4'b0100, 3'd0, 1'b0, 2'b00);
    repeat (3) @(posedge clk);
    #1 check("reset_hold", 14'b0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1 check("press_across_reset", {3'b000, 3'b000, 4'b0100, 4'b1001});
    @(negedge clk) drive(3'b000, 3'b000, 4'b0000, 3'd2, 1'b1, 2'b00);
    @(posedge clk);
    #1 check("clear_car2", 14'b0);

    for (int i = 0; i < 25; i++) begin
      @(negedge clk) drive(tbl[i].up, tbl[i].down, tbl[i].in_b, tbl[i].pos, tbl[i].open, tbl[i].dir);
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Asynchronous reset between edges with pend_in = 1010.
    @(negedge clk) drive(3'b000, 3'b000, 4'b0000, 3'd0, 1'b0, 2'b00);
    @(posedge clk);
    #1 check("pre_async", {3'b000, 3'b000, 4'b1010, 4'b1001});
    #2 reset_n = 1'b0;
    #1 check("async_reset", 14'b0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1 check("after_async", 14'b0);

    // Held hall button sets once, and does not re-set after service.
    @(negedge clk) drive(3'b010, 3'b000, 4'b0000, 3'd0, 1'b0, 2'b00);
    @(posedge clk);
    #1 check("hold_press", {3'b010, 3'b000, 4'b0000, 4'b1001});
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 check($sformatf("hold%0d", i), {3'b010, 3'b000, 4'b0000, 4'b1001});
    end
    @(negedge clk) drive(3'b010, 3'b000, 4'b0000, 3'd1, 1'b1, 2'b01);
    @(posedge clk);
    #1 check("hold_served", 14'b0);
    @(negedge clk) drive(3'b010, 3'b000, 4'b0000, 3'd1, 1'b0, 2'b01);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check($sformatf("hold_no_reset%0d", i), 14'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
